// File: rtl/uncached_dbus_bridge.sv
// Single-beat bridge from the CPU data bus to the cache bus for uncached
// (kseg1 / MMIO) accesses; cached requests are left to the D-cache.
module uncached_dbus_bridge (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_dreq_valid,
    input  logic [31:0] i_dreq_addr,
    input  logic [2:0]  i_dreq_size,
    input  logic [3:0]  i_dreq_strobe,
    input  logic [31:0] i_dreq_data,
    input  logic        i_uncached,
    output logic        o_dresp_addr_ok,
    output logic        o_dresp_data_ok,
    output logic [31:0] o_dresp_data,
    output logic        o_creq_valid,
    output logic        o_creq_is_write,
    output logic [2:0]  o_creq_size,
    output logic [31:0] o_creq_addr,
    output logic [3:0]  o_creq_strobe,
    output logic [31:0] o_creq_data,
    output logic [3:0]  o_creq_len,
    input  logic        i_cresp_ready,
    input  logic        i_cresp_last,
    input  logic [31:0] i_cresp_data
);

    localparam logic [3:0] MLEN1 = 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_capture;

    logic [31:0] r_addr;
    logic [2:0]  r_size;
    logic [3:0]  r_strobe;
    logic [31:0] r_wdata;
    logic        r_is_write;
    logic [31:0] r_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A beat without last is a protocol violation and is ignored outright.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_dreq_valid && i_uncached) begin
                    w_accept = 1'b1;
                    w_next   = BUSY;
                end
            end
            BUSY: begin
                if (i_cresp_ready && i_cresp_last) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr     <= '0;
            r_size     <= '0;
            r_strobe   <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= i_dreq_addr;
            r_size     <= i_dreq_size;
            r_strobe   <= i_dreq_strobe;
            r_wdata    <= i_dreq_data;
            r_is_write <= |i_dreq_strobe;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= '0;
        end else if (w_capture) begin
            r_rdata <= i_cresp_data;
        end
    end

    // addr_ok is combinational, so it is gated by reset to read 0 at once.
    assign o_dresp_addr_ok = resetn && (r_state == IDLE)
                             && i_dreq_valid && i_uncached;
    assign o_dresp_data_ok = (r_state == DONE);
    assign o_dresp_data    = r_rdata;

    assign o_creq_valid    = (r_state == BUSY);
    assign o_creq_is_write = r_is_write;
    assign o_creq_size     = r_size;
    assign o_creq_addr     = r_addr;
    assign o_creq_strobe   = r_strobe;
    assign o_creq_data     = r_wdata;
    assign o_creq_len      = MLEN1;

endmodule

// File: tb/tb_uncached_dbus_bridge.sv
// Cycle-by-cycle vector bench for uncached_dbus_bridge plus
// hand-written reset sequences.
module tb_uncached_dbus_bridge;

    localparam logic [2:0] MSIZE4 = 3'd2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        dv;
    logic [31:0] da;
    logic [2:0]  dsz;
    logic [3:0]  ds;
    logic [31:0] dd;
    logic        unc;
    logic        aok;
    logic        dok;
    logic [31:0] rdat;
    logic        cv;
    logic        cw;
    logic [2:0]  csz;
    logic [31:0] ca;
    logic [3:0]  cs;
    logic [31:0] cd;
    logic [3:0]  clen;
    logic        rdy;
    logic        lst;
    logic [31:0] rd;

    int n_tot  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uncached_dbus_bridge dut (
        .clk             (clk),
        .resetn          (resetn),
        .i_dreq_valid    (dv),
        .i_dreq_addr     (da),
        .i_dreq_size     (dsz),
        .i_dreq_strobe   (ds),
        .i_dreq_data     (dd),
        .i_uncached      (unc),
        .o_dresp_addr_ok (aok),
        .o_dresp_data_ok (dok),
        .o_dresp_data    (rdat),
        .o_creq_valid    (cv),
        .o_creq_is_write (cw),
        .o_creq_size     (csz),
        .o_creq_addr     (ca),
        .o_creq_strobe   (cs),
        .o_creq_data     (cd),
        .o_creq_len      (clen),
        .i_cresp_ready   (rdy),
        .i_cresp_last    (lst),
        .i_cresp_data    (rd)
    );

    typedef struct {
        logic        v;
        logic        u;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] wd;
        logic        rdy;
        logic        lst;
        logic [31:0] rd;
        logic        e_aok;
        logic        e_dok;
        logic [31:0] e_dd;
        logic        e_cv;
        logic        e_cw;
        logic [31:0] e_ca;
        logic [3:0]  e_cs;
        logic [31:0] e_cwd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic v, input logic u,
        input logic [31:0] a, input logic [3:0] s,
        input logic [31:0] wd, input logic r,
        input logic l, input logic [31:0] rdd,
        input logic eaok, input logic edok,
        input logic [31:0] edd, input logic ecv,
        input logic ecw, input logic [31:0] eca,
        input logic [3:0] ecs, input logic [31:0] ecwd
    );
        vec_t t;
        t.v = v; t.u = u; t.a = a; t.s = s;
        t.wd = wd; t.rdy = r; t.lst = l; t.rd = rdd;
        t.e_aok = eaok; t.e_dok = edok; t.e_dd = edd;
        t.e_cv = ecv; t.e_cw = ecw; t.e_ca = eca;
        t.e_cs = ecs; t.e_cwd = ecwd;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic v, input logic u,
                         input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] wd, input logic r,
                         input logic l, input logic [31:0] rdd);
        dv = v; unc = u; da = a; dsz = MSIZE4;
        ds = s; dd = wd; rdy = r; lst = l; rd = rdd;
    endtask

    localparam logic [31:0] LA = 32'h1FAF_F000;
    localparam logic [31:0] SA = 32'h1FD0_0010;
    localparam logic [31:0] CA = 32'h1FC0_0100;
    localparam logic [31:0] B1 = 32'h1FC0_0000;
    localparam logic [31:0] B2 = 32'h1FC0_0004;
    localparam logic [31:0] GA = 32'h1FE0_0008;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] CF = 32'hCAFE_F00D;
    localparam logic [31:0] W1 = 32'h1111_0000;
    localparam logic [31:0] W2 = 32'h2222_0000;
    localparam logic [31:0] A5 = 32'hA5A5_A5A5;

    initial begin
        // uncached load, ready on the 3rd BUSY cycle
        tbl.push_back(mk(1,1,LA,0,0, 0,0,0, 1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0, 1,0,LA,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0, 1,0,LA,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,DB, 0,0,0, 1,0,LA,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,DB, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,DB, 0,0,0,0,0));
        // uncached store, ready immediately
        tbl.push_back(mk(1,1,SA,4'b0011,32'h1234_5678, 0,0,0,
                         1,0,DB, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,CF, 0,0,DB,
                         1,1,SA,4'b0011,32'h1234_5678));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,CF, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,CF, 0,0,0,0,0));
        // cached request held; stray ready must not be captured
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(1,0,CA,0,0, 1,1,32'h1111_1111,
                             0,0,CF, 0,0,0,0,0));
        // back-to-back loads, valid held continuously
        tbl.push_back(mk(1,1,B1,0,0, 0,0,0, 1,0,CF, 0,0,0,0,0));
        tbl.push_back(mk(1,1,B2,0,0, 1,1,W1, 0,0,CF, 1,0,B1,0,0));
        tbl.push_back(mk(1,1,B2,0,0, 0,0,0, 0,1,W1, 0,0,0,0,0));
        tbl.push_back(mk(1,1,B2,0,0, 0,0,0, 1,0,W1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,W2, 0,0,W1, 1,0,B2,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,W2, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,W2, 0,0,0,0,0));
        // ready without last is ignored
        tbl.push_back(mk(1,1,GA,0,0, 0,0,0, 1,0,W2, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,32'hFFFF_0000, 0,0,W2,
                         1,0,GA,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,32'hFFFF_0000, 0,0,W2,
                         1,0,GA,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,A5, 0,0,W2, 1,0,GA,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,A5, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,A5, 0,0,0,0,0));

        // reset state, with an uncached request already presented
        resetn = 1'b0;
        drive(1,1,32'h1FAF_0000,4'hF,32'h5555_5555, 1,1,32'h7777_7777);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst addr_ok", {31'd0, aok}, 32'd0);
        chk("rst data_ok", {31'd0, dok}, 32'd0);
        chk("rst data", rdat, 32'd0);
        chk("rst creq.valid", {31'd0, cv}, 32'd0);
        chk("rst creq.is_write", {31'd0, cw}, 32'd0);
        chk("rst creq.size", {29'd0, csz}, 32'd0);
        chk("rst creq.addr", ca, 32'd0);
        chk("rst creq.strobe", {28'd0, cs}, 32'd0);
        chk("rst creq.data", cd, 32'd0);
        chk("rst creq.len", {28'd0, clen}, 32'd0);
        @(negedge clk);
        drive(0,0,0,0,0, 0,0,0);
        resetn = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].u, tbl[i].a, tbl[i].s,
                  tbl[i].wd, tbl[i].rdy, tbl[i].lst, tbl[i].rd);
            #1;
            chk($sformatf("v%0d addr_ok", i), {31'd0, aok},
                {31'd0, tbl[i].e_aok});
            chk($sformatf("v%0d data_ok", i), {31'd0, dok},
                {31'd0, tbl[i].e_dok});
            chk($sformatf("v%0d data", i), rdat, tbl[i].e_dd);
            chk($sformatf("v%0d creq.valid", i), {31'd0, cv},
                {31'd0, tbl[i].e_cv});
            if (tbl[i].e_cv) begin
                chk($sformatf("v%0d creq.is_write", i), {31'd0, cw},
                    {31'd0, tbl[i].e_cw});
                chk($sformatf("v%0d creq.addr", i), ca, tbl[i].e_ca);
                chk($sformatf("v%0d creq.strobe", i), {28'd0, cs},
                    {28'd0, tbl[i].e_cs});
                chk($sformatf("v%0d creq.data", i), cd, tbl[i].e_cwd);
                chk($sformatf("v%0d creq.size", i), {29'd0, csz},
                    {29'd0, MSIZE4});
                chk($sformatf("v%0d creq.len", i), {28'd0, clen},
                    32'd0);
            end
        end

        // reset asserted mid-BUSY abandons the transaction at once
        @(negedge clk);
        drive(1,1,32'h1FD0_0020,4'hF,32'h0BAD_F00D, 0,0,0);
        #1;
        chk("mid accept addr_ok", {31'd0, aok}, 32'd1);
        @(negedge clk);
        drive(1,1,32'h1FD0_0020,4'hF,32'h0BAD_F00D, 0,0,0);
        #1;
        chk("mid busy creq.valid", {31'd0, cv}, 32'd1);
        chk("mid busy creq.addr", ca, 32'h1FD0_0020);
        resetn = 1'b0;
        #1;
        chk("mid rst creq.valid", {31'd0, cv}, 32'd0);
        chk("mid rst creq.addr", ca, 32'd0);
        chk("mid rst creq.is_write", {31'd0, cw}, 32'd0);
        chk("mid rst addr_ok", {31'd0, aok}, 32'd0);
        chk("mid rst data_ok", {31'd0, dok}, 32'd0);
        chk("mid rst data", rdat, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        drive(1,1,32'h1FAF_0004,4'h0,32'd0, 0,0,0);
        #1;
        chk("post rst addr_ok", {31'd0, aok}, 32'd1);
        chk("post rst creq.valid", {31'd0, cv}, 32'd0);
        @(negedge clk);
        drive(0,0,0,0,0, 1,1,32'h600D_CAFE);
        #1;
        chk("post rst creq.valid busy", {31'd0, cv}, 32'd1);
        chk("post rst creq.addr", ca, 32'h1FAF_0004);
        chk("post rst creq.is_write", {31'd0, cw}, 32'd0);
        @(negedge clk);
        drive(0,0,0,0,0, 0,0,0);
        #1;
        chk("post rst data_ok", {31'd0, dok}, 32'd1);
        chk("post rst data", rdat, 32'h600D_CAFE);
        @(negedge clk);
        #1;
        chk("post rst data_ok drop", {31'd0, dok}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/uncached_dbus_bridge.md
# uncached_dbus_bridge

Consumes the translated data-bus request and the `d_uncached` flag produced by the data-side address translator. Services each uncached (kseg1 / MMIO) access as a single-beat transaction on the cache bus. Returns the `addr_ok` / `data_ok` handshake to the CPU. Cached accesses are ignored here and are left to the D-cache.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `dreq`  in  dbus_req_t  translated request: valid, addr (physical), size, strobe, data.
- `uncached`  in  1  request is uncached; the bridge only accepts requests with this set.
- `dresp`  out  dbus_resp_t  addr_ok, data_ok, data back to the CPU.
- `creq`  out  cbus_req_t  valid, is_write, size, addr, strobe, data, len.
- `cresp`  in  cbus_resp_t  ready, last, data from the memory/MMIO side.

## Operation
- State machine: IDLE, BUSY, DONE.
- IDLE
  - `dresp.addr_ok = dreq.valid && uncached` (combinational).
  - On that condition at a clock edge: latch addr, size, strobe and data; set `is_write = |strobe`; go to BUSY.
  - `dreq.valid && !uncached`: no response, stay in IDLE.
- BUSY
  - `creq.valid = 1` with the latched fields and `creq.len = MLEN1` (single beat).
  - `creq.is_write` and `creq.strobe` come from the latch; `creq.data` = latched store data.
  - `creq` is stable for the whole state; no field changes while waiting.
  - On `cresp.ready && cresp.last`: capture `cresp.data` into the response register, go to DONE.
  - `cresp.ready && !cresp.last` is a protocol violation: no state change, data not captured.
- DONE
  - `dresp.data_ok = 1` for exactly one cycle; `dresp.data` = captured word (don't-care for writes, driven from the register regardless).
  - Next state is IDLE unconditionally.
- `addr_ok` is asserted only in IDLE, so at most one uncached access is outstanding. A request presented during BUSY or DONE is held by the CPU and accepted in the next IDLE cycle.
- No address checking or translation is done here: `creq.addr` = latched `dreq.addr` bit-exact.

## Timing
- Reset (`resetn` low, asynchronous): state = IDLE.
  - `dresp.addr_ok` / `data_ok` = 0, `dresp.data` = 0.
  - `creq.valid` = 0; all other `creq` fields = 0.
  - Latch and data registers = 0.
- Reset asserted mid-BUSY: `creq.valid` drops immediately and the transaction is abandoned. The downstream side shares `resetn` and must abandon it too.
- Latency: accept at edge T0; `creq.valid` high from T0+ onward. If `cresp.ready && last` is sampled at edge Tk, `data_ok` is high in the cycle after Tk. Minimum: `addr_ok` in cycle 0, `data_ok` in cycle 2.
- `addr_ok` and `data_ok` are never high in the same cycle.
- `data_ok` is a single-cycle pulse; the CPU must consume it in that cycle.
- Back-to-back requests: the earliest second `addr_ok` is the cycle after DONE (3-cycle minimum period).
- `dresp.data` holds its value until the next capture.

## Test plan
- Uncached load: dreq {valid=1, addr=0x1FAF_F000, size=MSIZE4, strobe=0}, uncached=1; `cresp.ready` = `last` = 1 with data=0xDEAD_BEEF on the 3rd BUSY cycle -> addr_ok in cycle 0; creq {valid=1, is_write=0, addr=0x1FAF_F000, len=MLEN1} held stable; data_ok=1 with data=0xDEAD_BEEF exactly one cycle after the ready edge.
- Uncached store: strobe=4'b0011, data=0x1234_5678, addr=0x1FD0_0010; ready at first BUSY cycle -> creq.is_write=1, strobe=0011, data=0x1234_5678; data_ok in cycle 2.
- Cached request: dreq.valid=1, uncached=0 held 10 cycles -> addr_ok=0, creq.valid=0, data_ok=0 throughout.
- Back-to-back: two uncached loads with valid held continuously, ready immediate -> addr_ok in cycles 0 and 3; each data_ok one cycle after its ready edge; no overlap.
- Reset mid-BUSY: drop resetn while creq.valid=1 -> creq.valid=0 and all dresp fields 0 asynchronously; after release, state IDLE and a new request is accepted normally.
- Protocol guard: ready=1, last=0 for 2 cycles, then ready=last=1 with data=0xA5A5_A5A5 -> no data_ok during the guard cycles; data_ok with 0xA5A5_A5A5 after the final edge.
